// File: rtl/aes_round_ctrl_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared types and constants for the AES-128 round controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SUB   = 3'd2,
        ST_UPD   = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } ctrl_state_t;

    localparam int         NROUNDS   = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // GF(2^8) multiply-by-two; also used by the MixColumns datapath.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
// ============================================================================
// Module : aes_round_ctrl_if
// Brief  : Load strobe and datapath control bundle of the AES round sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aes_round_ctrl_if;

    logic       load;
    logic       state_init;
    logic       sub_en;
    logic       upd_en;
    logic       mix_bypass;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       ct_latch;
    logic       busy;
    logic       done;

    // Controller side.
    modport master (
        input  load,
        output state_init, sub_en, upd_en, mix_bypass, round, rcon,
        output ct_latch, busy, done
    );

    // MCU / datapath side.
    modport slave (
        output load,
        input  state_init, sub_en, upd_en, mix_bypass, round, rcon,
        input  ct_latch, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/aes_round_ctrl_load_sync.sv
// ============================================================================
// Module : load_sync
// Brief  : Multi-flop synchronizer with rise/fall pulse detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              delay_q;
    logic              level_s;

    // Resetting to RESET_VAL keeps a held-high strobe from looking like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {STAGES{RESET_VAL}};
            delay_q <= RESET_VAL;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_i};
            delay_q <= sync_q[STAGES-1];
        end
    end

    assign level_s = sync_q[STAGES-1];
    assign rise_o  =  level_s & ~delay_q;
    assign fall_o  = ~level_s &  delay_q;

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module : aes_round_ctrl
// Brief  : AES-128 round sequencer: INIT, ten two-cycle rounds, ciphertext latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NROUNDS     = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    aes_round_ctrl_if.master       bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    logic        load_rise;
    logic        load_fall;

    ctrl_state_t state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [7:0]  rcon_q,  rcon_d;

    logic        state_init_w;
    logic        sub_en_w;
    logic        upd_en_w;
    logic        mix_bypass_w;
    logic [3:0]  round_w;
    logic [7:0]  rcon_w;
    logic        ct_latch_w;
    logic        busy_w;
    logic        done_w;

    load_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (bus.load),
        .rise_o  (load_rise),
        .fall_o  (load_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Outputs decode from state only, so an asynchronous reset clears them at once.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        state_init_w = 1'b0;
        sub_en_w     = 1'b0;
        upd_en_w     = 1'b0;
        mix_bypass_w = 1'b0;
        round_w      = 4'd0;
        rcon_w       = 8'h00;
        ct_latch_w   = 1'b0;
        busy_w       = 1'b0;
        done_w       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                round_d = 4'd0;
                rcon_d  = 8'h00;
                if (load_fall) begin
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                state_init_w = 1'b1;
                busy_w       = 1'b1;
                round_d      = 4'd1;
                rcon_d       = RCON_INIT;
                state_d      = load_rise ? ST_IDLE : ST_SUB;
            end

            ST_SUB: begin
                sub_en_w = 1'b1;
                busy_w   = 1'b1;
                round_w  = round_q;
                rcon_w   = rcon_q;
                state_d  = load_rise ? ST_IDLE : ST_UPD;
            end

            ST_UPD: begin
                upd_en_w     = 1'b1;
                busy_w       = 1'b1;
                round_w      = round_q;
                rcon_w       = rcon_q;
                mix_bypass_w = (round_q == LAST_ROUND);
                if (load_rise) begin
                    state_d = ST_IDLE;
                end else if (round_q < LAST_ROUND) begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    state_d = ST_SUB;
                end else begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                ct_latch_w = 1'b1;
                busy_w     = 1'b1;
                state_d    = load_rise ? ST_IDLE : ST_DONE;
            end

            ST_DONE: begin
                done_w = 1'b1;
                if (load_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.state_init = state_init_w;
    assign bus.sub_en     = sub_en_w;
    assign bus.upd_en     = upd_en_w;
    assign bus.mix_bypass = mix_bypass_w;
    assign bus.round      = round_w;
    assign bus.rcon       = rcon_w;
    assign bus.ct_latch   = ct_latch_w;
    assign bus.busy       = busy_w;
    assign bus.done       = done_w;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module : tb_aes_round_ctrl
// Brief  : Directed self-checking bench for the AES round sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(
        .SYNC_STAGES (2),
        .NROUNDS     (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // {state_init, sub_en, upd_en, mix_bypass, round, rcon, ct_latch, busy, done}
    logic [18:0] obs;
    assign obs = {bus.state_init, bus.sub_en, bus.upd_en, bus.mix_bypass,
                  bus.round, bus.rcon, bus.ct_latch, bus.busy, bus.done};

    // Expected outputs after edge e, where edge 0 is the first edge sampling load=0.
    function automatic logic [18:0] exp_vec(input int e);
        logic       si, se, ue, mb, cl, bz, dn;
        logic [3:0] rd;
        logic [7:0] rc;
        int         k;
        {si, se, ue, mb, cl, bz, dn} = 7'b0;
        rd = 4'd0;
        rc = 8'h00;
        if (e == 2) begin
            si = 1'b1;
            bz = 1'b1;
        end else if (e >= 3 && e <= 22) begin
            k  = (e - 3) / 2 + 1;
            rd = 4'(k);
            rc = RCON_TAB[k-1];
            bz = 1'b1;
            if (((e - 3) % 2) == 0) begin
                se = 1'b1;
            end else begin
                ue = 1'b1;
                mb = (k == 10);
            end
        end else if (e == 23) begin
            cl = 1'b1;
            bz = 1'b1;
        end else if (e >= 24) begin
            dn = 1'b1;
        end
        return {si, se, ue, mb, rd, rc, cl, bz, dn};
    endfunction

    task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic v);
        @(negedge clk);
        bus.load = v;
    endtask

    // Drop load and check every cycle of a full encryption into DONE.
    task automatic run_full(input string tag);
        set_load(1'b0);
        for (int e = 0; e <= 27; e++) begin
            tick();
            chk(tag, obs, exp_vec(e));
        end
    endtask

    // Raise load from DONE: done holds two edges, clears on the third.
    task automatic leave_done();
        set_load(1'b1);
        tick();
        chk("done_hold0", obs, 19'h00001);
        tick();
        chk("done_hold1", obs, 19'h00001);
        tick();
        chk("done_clear", obs, 19'h00000);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        bus.load = 1'b1;
        reset_n  = 1'b0;

        #3;
        chk("reset_outputs", obs, 19'h00000);
        @(negedge clk);
        reset_n = 1'b1;

        // Load held high: no strobes at all.
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("idle_load_high", obs, 19'h00000);
        end

        run_full("run1");
        leave_done();

        // Second encryption after leaving DONE.
        run_full("run2");
        leave_done();

        // Abort during round 5.
        set_load(1'b0);
        for (int e = 0; e <= 11; e++) begin
            tick();
        end
        chk("abort_sub5", obs, exp_vec(11));
        set_load(1'b1);
        tick();
        chk("abort_upd5", obs, exp_vec(12));
        tick();
        chk("abort_sub6", obs, exp_vec(13));
        tick();
        chk("abort_idle", obs, 19'h00000);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("abort_quiet", obs, 19'h00000);
        end

        run_full("run_after_abort");
        leave_done();

        // Asynchronous reset in the middle of UPD1.
        set_load(1'b0);
        for (int e = 0; e <= 4; e++) begin
            tick();
        end
        chk("pre_reset_upd1", obs, exp_vec(4));
        #2;
        reset_n  = 1'b0;
        bus.load = 1'b1;
        #1;
        chk("async_reset", obs, 19'h00000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_reset_idle", obs, 19'h00000);
        end

        run_full("run_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath behind the SPI front end. It watches the SPI `load` strobe from the MCU, starts one encryption when `load` falls, and steps the datapath through the initial AddRoundKey, ten SubBytes/ShiftRows/MixColumns/AddRoundKey rounds and ciphertext capture. It generates the round constant and asserts `done` so the MCU can shift the ciphertext out. The datapath uses synchronous (EBR) S-boxes, so every round takes two cycles.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in the `load` synchronizer (≥2).
- `NROUNDS`, 10: AES rounds; only 10 (AES-128) is supported.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: raw SPI load strobe from the MCU, asynchronous to `clk`. It is high while plaintext and key are being shifted in.
- `state_init` out 1: datapath loads state ← plaintext ^ key and roundkey ← key.
- `sub_en` out 1: issues the S-box reads for the state bytes and the key-schedule bytes.
- `upd_en` out 1: the state register and roundkey register take their next-round values.
- `mix_bypass` out 1: skip MixColumns; valid with `upd_en`.
- `round` out 4: current round, 0 to 10.
- `rcon` out 8: round constant for the key schedule; valid during SUB and UPD.
- `ct_latch` out 1: capture state into the ciphertext output shift register.
- `busy` out 1: an encryption is in progress (INIT through LATCH).
- `done` out 1: ciphertext is ready to shift out.

## Operation
- Synchronizer: `load` passes through `SYNC_STAGES` flops to give `load_s`, then through one delay flop to give `load_d`.
  - fall = `load_s` & ~... specifically, fall = ~`load_s` & `load_d`.
  - rise = `load_s` & ~`load_d`.
- States:
  - IDLE → INIT on fall.
  - INIT: 1 cycle, `state_init`=1, `round`=0, rcon register ← 8'h01. Then → SUB with round=1.
  - SUB: `sub_en`=1. Then → UPD.
  - UPD: `upd_en`=1, `mix_bypass`=(round==10).
    - If round<10: round+1, rcon ← xtime(rcon), → SUB.
    - Otherwise → LATCH.
  - LATCH: `ct_latch`=1 for 1 cycle. Then → DONE.
  - DONE: `done`=1. Held until rise, then → IDLE.
- xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Sequence for rounds 1–10: 01 02 04 08 10 20 40 80 1B 36.
- `rcon` outputs 8'h00 outside SUB/UPD. `round` outputs 0 in IDLE, INIT, LATCH and DONE.
- All strobes are one-hot per cycle; at most one of `state_init`/`sub_en`/`upd_en`/`ct_latch` is high.
- `busy` is high in INIT, SUB, UPD and LATCH.

## Timing
- Reset: all outputs 0, FSM in IDLE, synchronizer and delay flops set to 1 so that no fall is seen out of reset.
- Latency, with edge 0 = first `clk` edge that samples `load`=0 (SYNC_STAGES=2):
  - INIT occupies edge 2–3.
  - SUB1 starts at edge 3.
  - UPD10 occupies edge 22–23.
  - LATCH occupies edge 23–24.
  - `done` is high from edge 24.
  - Total: 22 cycles INIT→DONE.
- Rise during INIT/SUB/UPD/LATCH aborts the encryption: next state is IDLE, no `ct_latch`, `done` stays 0.
- Fall while in DONE cannot occur without a prior rise. A rise in DONE clears `done` on the next edge.
- A `load` pulse shorter than one `clk` period may be missed. This is acceptable because SPI framing holds `load` for many cycles.
- Deasserting `reset_n` mid-round: immediate IDLE and all outputs 0. Datapath contents are don't-care.

## Structure
- `aes_pkg`:
  - `ctrl_state_t` enum: IDLE, INIT, SUB, UPD, LATCH, DONE.
  - `NROUNDS`=10.
  - `RCON_INIT`=8'h01.
  - `xtime()` function, shared with the MixColumns datapath.
- Sub-module `load_sync`: parameterized synchronizer plus rise/fall pulse detector, reused for any MCU-driven strobe.
- The FSM, round counter and rcon register stay in `aes_round_ctrl`.

## Test plan
- Reset, then hold `load`=1 for 300 cycles → all outputs 0, `busy`=0, no strobes.
- Drop `load` once → `state_init` pulses at edge 2, then exactly 10 `sub_en` and 10 `upd_en` pulses in alternation.
  - `rcon` during SUB1..SUB10 = 01,02,04,08,10,20,40,80,1B,36.
  - `mix_bypass`=1 only on UPD10.
  - `ct_latch` fires at edge 23; `done`=1 at edge 24.
- Drive the full system with key 2B7E151628AED2A6ABF7158809CF4F3C and plaintext 3243F6A8885A308D313198A2E0370734 → ciphertext shifted out = 3925841D02DC09FBDC118597196A0B32.
- Raise `load` during round 5 → FSM returns to IDLE within `SYNC_STAGES`+1 cycles, no `ct_latch`, `done` stays 0. A subsequent fall produces a clean 22-cycle run.
- From DONE, raise `load` → `done` clears. Drop `load` again → second encryption; C.1 vector (key 000102…0F, plaintext 00112233…FF) gives ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
- Assert `reset_n`=0 in mid-UPD → outputs 0 asynchronously, before the next edge. After release with `load`=1, no spurious start.
